// File: rtl/jt1942_rom_pkg.sv
// Shared types and constants for the 1942 graphics-ROM scheduler.
// Client widths, region offsets, FSM state and client indices.
package jt1942_rom_pkg;

  localparam int unsigned SDRAM_AW = 22;
  localparam int unsigned SCR_AW   = 14;
  localparam int unsigned CHAR_AW  = 13;
  localparam int unsigned OBJ_AW   = 15;
  localparam int unsigned LAT_AW   = 15;
  localparam int unsigned SCR_DW   = 24;
  localparam int unsigned CHAR_DW  = 16;
  localparam int unsigned OBJ_DW   = 16;
  localparam int unsigned DOUT_W   = 32;
  localparam int unsigned CL_W     = 2;

  localparam logic [CL_W-1:0] CL_SCR  = 2'd0;
  localparam logic [CL_W-1:0] CL_CHAR = 2'd1;
  localparam logic [CL_W-1:0] CL_OBJ  = 2'd2;

  localparam logic [SDRAM_AW-1:0] SCR_OFFSET_DEF  = 22'h01_0000;
  localparam logic [SDRAM_AW-1:0] CHAR_OFFSET_DEF = 22'h00_8000;
  localparam logic [SDRAM_AW-1:0] OBJ_OFFSET_DEF  = 22'h02_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/jt1942_rom_sched_if.sv
// Client and SDRAM-port signals of the ROM scheduler.
// slave = the scheduler, master = tile generators plus SDRAM controller.
interface jt1942_rom_sched_if;
  import jt1942_rom_pkg::*;

  logic [SCR_AW-1:0]   scr_addr;
  logic                scr_cs;
  logic                scr_ok;
  logic [SCR_DW-1:0]   scr_data;
  logic [CHAR_AW-1:0]  char_addr;
  logic                char_cs;
  logic                char_ok;
  logic [CHAR_DW-1:0]  char_data;
  logic [OBJ_AW-1:0]   obj_addr;
  logic                obj_cs;
  logic                obj_ok;
  logic [OBJ_DW-1:0]   obj_data;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_req;
  logic                sdram_ack;
  logic                sdram_rdy;
  logic [DOUT_W-1:0]   sdram_dout;

  modport slave (
    input  scr_addr, scr_cs, char_addr, char_cs, obj_addr, obj_cs,
    input  sdram_ack, sdram_rdy, sdram_dout,
    output scr_ok, scr_data, char_ok, char_data, obj_ok, obj_data,
    output sdram_addr, sdram_req
  );

  modport master (
    output scr_addr, scr_cs, char_addr, char_cs, obj_addr, obj_cs,
    output sdram_ack, sdram_rdy, sdram_dout,
    input  scr_ok, scr_data, char_ok, char_data, obj_ok, obj_data,
    input  sdram_addr, sdram_req
  );

endinterface

// File: rtl/jt1942_rom_slot.sv
// One-word cache for a single ROM client: remembers the last fetched
// address/data and flags a hit (ok) or a needed fetch (pending).
module jt1942_rom_slot #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cs,
  input  logic [AW-1:0] i_addr,
  input  logic          i_inflight,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_addr,
  input  logic [DW-1:0] i_load_data,
  output logic          o_ok,
  output logic          o_pending,
  output logic [DW-1:0] o_data
);

  logic [AW-1:0] r_last_addr;
  logic          r_valid;
  logic          w_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_addr <= '0;
      r_valid     <= 1'b0;
      o_data      <= '0;
    end else if (i_load) begin
      r_last_addr <= i_load_addr;
      r_valid     <= 1'b1;
      o_data      <= i_load_data;
    end
  end

  // Hit only while the client still asks for the cached address
  assign w_ok      = i_cs & r_valid & (i_addr == r_last_addr);
  assign o_ok      = w_ok;
  assign o_pending = i_cs & ~w_ok & ~i_inflight;

endmodule

// File: rtl/jt1942_rom_sched.sv
// Arbitrates the shared graphics-ROM port among scroll, char and object
// clients with fixed priority scr > char > obj and a one-word cache each.
module jt1942_rom_sched
  import jt1942_rom_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] SCR_OFFSET  = SCR_OFFSET_DEF,
  parameter logic [SDRAM_AW-1:0] CHAR_OFFSET = CHAR_OFFSET_DEF,
  parameter logic [SDRAM_AW-1:0] OBJ_OFFSET  = OBJ_OFFSET_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  jt1942_rom_sched_if.slave  bus
);

  state_t              r_state;
  logic [CL_W-1:0]     r_gnt;
  logic [LAT_AW-1:0]   r_lat_addr;
  logic [SDRAM_AW-1:0] r_sdram_addr;
  logic                r_sdram_req;

  logic w_busy, w_load;
  logic w_scr_pend, w_char_pend, w_obj_pend;
  logic w_unused_dout;

  assign w_busy = (r_state != IDLE);
  // Ack+rdy together in REQ completes the transaction in that same cycle
  assign w_load = bus.sdram_rdy &
                  ((r_state == WAIT) | ((r_state == REQ) & bus.sdram_ack));
  assign w_unused_dout = ^bus.sdram_dout[DOUT_W-1:SCR_DW];

  jt1942_rom_slot #(.AW(SCR_AW), .DW(SCR_DW)) u_scr (
    .clk(clk), .rst_n(rst_n),
    .i_cs(bus.scr_cs), .i_addr(bus.scr_addr),
    .i_inflight(w_busy & (r_gnt == CL_SCR)),
    .i_load(w_load & (r_gnt == CL_SCR)),
    .i_load_addr(SCR_AW'(r_lat_addr)),
    .i_load_data(bus.sdram_dout[SCR_DW-1:0]),
    .o_ok(bus.scr_ok), .o_pending(w_scr_pend), .o_data(bus.scr_data)
  );

  jt1942_rom_slot #(.AW(CHAR_AW), .DW(CHAR_DW)) u_char (
    .clk(clk), .rst_n(rst_n),
    .i_cs(bus.char_cs), .i_addr(bus.char_addr),
    .i_inflight(w_busy & (r_gnt == CL_CHAR)),
    .i_load(w_load & (r_gnt == CL_CHAR)),
    .i_load_addr(CHAR_AW'(r_lat_addr)),
    .i_load_data(bus.sdram_dout[CHAR_DW-1:0]),
    .o_ok(bus.char_ok), .o_pending(w_char_pend), .o_data(bus.char_data)
  );

  jt1942_rom_slot #(.AW(OBJ_AW), .DW(OBJ_DW)) u_obj (
    .clk(clk), .rst_n(rst_n),
    .i_cs(bus.obj_cs), .i_addr(bus.obj_addr),
    .i_inflight(w_busy & (r_gnt == CL_OBJ)),
    .i_load(w_load & (r_gnt == CL_OBJ)),
    .i_load_addr(OBJ_AW'(r_lat_addr)),
    .i_load_data(bus.sdram_dout[OBJ_DW-1:0]),
    .o_ok(bus.obj_ok), .o_pending(w_obj_pend), .o_data(bus.obj_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_gnt        <= CL_SCR;
      r_lat_addr   <= '0;
      r_sdram_addr <= '0;
      r_sdram_req  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_scr_pend) begin
            r_gnt        <= CL_SCR;
            r_lat_addr   <= LAT_AW'(bus.scr_addr);
            r_sdram_addr <= SCR_OFFSET + SDRAM_AW'(bus.scr_addr);
          end else if (w_char_pend) begin
            r_gnt        <= CL_CHAR;
            r_lat_addr   <= LAT_AW'(bus.char_addr);
            r_sdram_addr <= CHAR_OFFSET + SDRAM_AW'(bus.char_addr);
          end else if (w_obj_pend) begin
            r_gnt        <= CL_OBJ;
            r_lat_addr   <= LAT_AW'(bus.obj_addr);
            r_sdram_addr <= OBJ_OFFSET + SDRAM_AW'(bus.obj_addr);
          end
          if (w_scr_pend | w_char_pend | w_obj_pend) begin
            r_sdram_req <= 1'b1;
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (bus.sdram_ack) begin
            r_sdram_req <= 1'b0;
            r_state     <= bus.sdram_rdy ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (bus.sdram_rdy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sdram_addr = r_sdram_addr;
  assign bus.sdram_req  = r_sdram_req;

endmodule
